// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the multi-digit seven-segment driver.
//   - Active-low segment glyphs, bit6 = a ... bit0 = g.
//   - Conversion FSM state enum shared by the BCD engine.
//   - glyph(): maps a BCD nibble to its segment pattern.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_t;

    // Non-decimal nibbles cannot occur after a valid double-dabble run;
    // they fall back to a dark digit rather than a misleading pattern.
    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq.sv
// ssd_bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk    : clock
//   rst    : synchronous active-low reset
//   start  : load bin_in and begin a conversion (honoured only when idle)
//   bin_in : unsigned binary magnitude
//   busy   : high from the cycle after start until the result is handed over
//   done   : one-cycle strobe; bcd is valid and stable while it is high
//   bcd    : packed BCD result, digit 0 in bits [3:0]
// One bit is consumed per CONVERT cycle, followed by a single COMMIT cycle,
// so busy lasts IN_WIDTH+1 cycles.
module ssd_bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int IN_WIDTH   = 13,
    parameter int BCD_DIGITS = (IN_WIDTH + 3) / 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_WIDTH-1:0]     bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    conv_state_t             state;
    conv_state_t             state_next;
    logic [IN_WIDTH-1:0]     bin_sr;
    logic [4*BCD_DIGITS-1:0] bcd_sr;
    logic [4*BCD_DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]        count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (count == CNT_W'(IN_WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction keeps every nibble decimal once it is doubled.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        bcd_sr <= '0;
                        count  <= '0;
                    end
                end
                CONVERT: begin
                    bcd_sr <= {bcd_adj[4*BCD_DIGITS-2:0], bin_sr[IN_WIDTH-1]};
                    bin_sr <= {bin_sr[IN_WIDTH-2:0], 1'b0};
                    count  <= count + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == COMMIT);
    assign bcd  = bcd_sr;

endmodule

// File: rtl/ssd_multi_digit_driver.sv
// ssd_multi_digit_driver: binary value to multiplexed common-anode display.
//   SSDClk      : display clock
//   rst         : synchronous active-low reset
//   value       : binary value to show
//   value_valid : load request, ignored while busy
//   signed_mode : value is two's complement (sampled with value_valid)
//   blank_lz    : blank leading zeros (live)
//   busy        : conversion in progress
//   overflow    : last committed value needed more digits than exist
//   Anode       : one-hot active-low digit enables, digit 0 rightmost
//   LED_out     : active-low segments, bit6 = a ... bit0 = g
module ssd_multi_digit_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int IN_WIDTH     = 13,
    parameter int REFRESH_BITS = 17
) (
    input  logic                  SSDClk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   value,
    input  logic                  value_valid,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] Anode,
    output logic [6:0]            LED_out
);

    localparam int BCD_DIGITS = (IN_WIDTH + 3) / 3;
    localparam int EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IDX_W      = $clog2(EXT_DIGITS + NUM_DIGITS + 2);

    logic                    start;
    logic [IN_WIDTH-1:0]     magnitude;
    logic                    neg_in;
    logic                    neg_pend;
    logic                    done;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [4*EXT_DIGITS-1:0] bcd_ext;
    logic [IDX_W-1:0]        bcd_msd;
    logic [IDX_W-1:0]        required;

    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic                    disp_neg;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [SEL_W-1:0]        digit_sel;
    logic [IDX_W-1:0]        disp_msd;
    logic [IDX_W-1:0]        sign_pos;
    logic [IDX_W-1:0]        sel_idx;
    logic [3:0]              cur_nibble;
    logic [6:0]              seg_next;

    assign start = value_valid && !busy;

    // Negating the most negative input wraps back to 2^(IN_WIDTH-1), which
    // is exactly the wanted magnitude when read as unsigned.
    always_comb begin
        if (signed_mode && value[IN_WIDTH-1]) begin
            magnitude = ~value + IN_WIDTH'(1);
            neg_in    = 1'b1;
        end else begin
            magnitude = value;
            neg_in    = 1'b0;
        end
    end

    ssd_bin2bcd_seq #(
        .IN_WIDTH   (IN_WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk    (SSDClk),
        .rst    (rst),
        .start  (start),
        .bin_in (magnitude),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    // Positions needed = highest nonzero digit + 1 (at least one), plus the sign.
    always_comb begin
        bcd_ext                     = '0;
        bcd_ext[4*BCD_DIGITS-1:0]   = bcd;
        bcd_msd                     = '0;
        for (int i = 0; i < EXT_DIGITS; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) bcd_msd = IDX_W'(i);
        end
        required = bcd_msd + IDX_W'(1) + IDX_W'(neg_pend);
    end

    // On overflow the previous digits are kept but hidden behind dashes.
    always_ff @(posedge SSDClk) begin
        if (!rst) begin
            neg_pend    <= 1'b0;
            overflow    <= 1'b0;
            disp_digits <= '0;
            disp_neg    <= 1'b0;
        end else begin
            if (start) neg_pend <= neg_in;
            if (done) begin
                if (required > IDX_W'(NUM_DIGITS)) begin
                    overflow <= 1'b1;
                end else begin
                    overflow    <= 1'b0;
                    disp_digits <= bcd_ext[4*NUM_DIGITS-1:0];
                    disp_neg    <= neg_pend;
                end
            end
        end
    end

    always_ff @(posedge SSDClk) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_sel   <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            if (&refresh_cnt) begin
                digit_sel <= (digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + SEL_W'(1);
            end
        end
    end

    // With blanking the minus hugs the number; otherwise it sits leftmost.
    always_comb begin
        disp_msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_digits[4*i +: 4] != 4'd0) disp_msd = IDX_W'(i);
        end
        sign_pos   = blank_lz ? disp_msd + IDX_W'(1) : IDX_W'(NUM_DIGITS - 1);
        sel_idx    = IDX_W'(digit_sel);
        cur_nibble = disp_digits[4*digit_sel +: 4];
        if (overflow) begin
            seg_next = SEG_MINUS;
        end else if (disp_neg && sel_idx == sign_pos) begin
            seg_next = SEG_MINUS;
        end else if (blank_lz && sel_idx != '0 && sel_idx > disp_msd) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = glyph(cur_nibble);
        end
    end

    always_ff @(posedge SSDClk) begin
        if (!rst) begin
            Anode   <= '1;
            LED_out <= SEG_BLANK;
        end else begin
            Anode   <= ~(NUM_DIGITS'(1) << digit_sel);
            LED_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_ssd_multi_digit_driver.sv
// tb_ssd_multi_digit_driver: self-checking bench for ssd_multi_digit_driver.
// Uses a short refresh period so a full scan takes 16 cycles. Directed
// vectors come from a table; random loads are checked against a decimal
// arithmetic model of what each digit should show.
module tb_ssd_multi_digit_driver;

    localparam int ND    = 4;
    localparam int IW    = 13;
    localparam int RB    = 2;
    localparam int BOUND = 64;

    localparam logic [6:0] G0  = 7'b0000001;
    localparam logic [6:0] G1  = 7'b1001111;
    localparam logic [6:0] G2  = 7'b0010010;
    localparam logic [6:0] G3  = 7'b0000110;
    localparam logic [6:0] G4  = 7'b1001100;
    localparam logic [6:0] G5  = 7'b0100100;
    localparam logic [6:0] G6  = 7'b0100000;
    localparam logic [6:0] G7  = 7'b0001111;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] G9  = 7'b0000100;
    localparam logic [6:0] DSH = 7'b1111110;
    localparam logic [6:0] BLK = 7'b1111111;

    logic          SSDClk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] value = '0;
    logic          value_valid = 1'b0;
    logic          signed_mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic          busy;
    logic          overflow;
    logic [ND-1:0] Anode;
    logic [6:0]    LED_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] value;
        logic          sm;
        logic          bl;
        logic          exp_ovf;
        logic [27:0]   exp_segs;
    } vec_t;

    vec_t vecs[10];

    always #5 SSDClk = ~SSDClk;

    ssd_multi_digit_driver #(
        .NUM_DIGITS   (ND),
        .IN_WIDTH     (IW),
        .REFRESH_BITS (RB)
    ) dut (
        .SSDClk      (SSDClk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .overflow    (overflow),
        .Anode       (Anode),
        .LED_out     (LED_out)
    );

    task automatic compareValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] digitSeg(input int d);
        case (d)
            0: return G0;
            1: return G1;
            2: return G2;
            3: return G3;
            4: return G4;
            5: return G5;
            6: return G6;
            7: return G7;
            8: return G8;
            default: return G9;
        endcase
    endfunction

    // Decimal model: what a reader of the board should see for a load.
    task automatic modelDisplay(input logic [IW-1:0] v, input logic sm, input logic bl,
                                output logic ovf, output logic [27:0] segs);
        int mag, ndig, t, p, d, sign_pos;
        bit neg;
        neg = sm && v[IW-1];
        mag = neg ? ((1 << IW) - int'(v)) : int'(v);
        ndig = 1;
        t = mag / 10;
        while (t > 0) begin
            ndig++;
            t = t / 10;
        end
        ovf = (ndig + int'(neg)) > ND;
        sign_pos = bl ? ndig : ND - 1;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = (mag / p) % 10;
            if (ovf)                          segs[7*i +: 7] = DSH;
            else if (neg && i == sign_pos)    segs[7*i +: 7] = DSH;
            else if (bl && i > 0 && i >= ndig) segs[7*i +: 7] = BLK;
            else                              segs[7*i +: 7] = digitSeg(d);
            p = p * 10;
        end
    endtask

    task automatic applyStimulus(input logic [IW-1:0] v, input logic sm, input logic bl,
                                 output int busy_cycles);
        @(negedge SSDClk);
        value       = v;
        signed_mode = sm;
        blank_lz    = bl;
        value_valid = 1'b1;
        @(negedge SSDClk);
        value_valid = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < BOUND) begin
            busy_cycles++;
            @(negedge SSDClk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_ovf, input logic [27:0] exp_segs);
        logic [ND-1:0] want;
        int n;
        repeat (2) @(negedge SSDClk);
        compareValue({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        for (int i = 0; i < ND; i++) begin
            want = ~(ND'(1) << i);
            n = 0;
            while (Anode !== want && n < BOUND) begin
                @(negedge SSDClk);
                n++;
            end
            if (n >= BOUND) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s anode%0d: got %b, expected %b", tag, i, Anode, want);
            end else begin
                compareValue($sformatf("%s digit%0d", tag, i), 32'(LED_out), 32'(exp_segs[7*i +: 7]));
            end
        end
    endtask

    initial begin
        int bc;
        int n;
        logic [IW-1:0] rv;
        logic rsm, rbl, movf;
        logic [27:0] msegs;

        vecs[0] = '{13'd1234, 1'b0, 1'b0, 1'b0, {G1, G2, G3, G4}};
        vecs[1] = '{13'd7,    1'b0, 1'b1, 1'b0, {BLK, BLK, BLK, G7}};
        vecs[2] = '{13'h1FD3, 1'b1, 1'b1, 1'b0, {BLK, DSH, G4, G5}};
        vecs[3] = '{13'h1C18, 1'b1, 1'b1, 1'b1, {DSH, DSH, DSH, DSH}};
        vecs[4] = '{13'd999,  1'b0, 1'b0, 1'b0, {G0, G9, G9, G9}};
        vecs[5] = '{13'h1C19, 1'b1, 1'b0, 1'b0, {DSH, G9, G9, G9}};
        vecs[6] = '{13'h1000, 1'b1, 1'b0, 1'b1, {DSH, DSH, DSH, DSH}};
        vecs[7] = '{13'd8191, 1'b0, 1'b1, 1'b0, {G8, G1, G9, G1}};
        vecs[8] = '{13'd0,    1'b0, 1'b1, 1'b0, {BLK, BLK, BLK, G0}};
        vecs[9] = '{13'h1FFF, 1'b1, 1'b0, 1'b0, {DSH, G0, G0, G1}};

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge SSDClk);
        compareValue("reset Anode", 32'(Anode), 32'hF);
        compareValue("reset LED_out", 32'(LED_out), 32'h7F);
        compareValue("reset busy", 32'(busy), 32'h0);
        compareValue("reset overflow", 32'(overflow), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge SSDClk);
        compareValue("anode one-hot after release", 32'($countones(~Anode)), 32'd1);

        // Directed table
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].value, vecs[k].sm, vecs[k].bl, bc);
            compareValue($sformatf("vec%0d busy cycles", k), 32'(bc), 32'd14);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_ovf, vecs[k].exp_segs);
        end

        // Live blank_lz toggle without a reload
        applyStimulus(13'd7, 1'b0, 1'b1, bc);
        checkOutput("blank on", 1'b0, {BLK, BLK, BLK, G7});
        blank_lz = 1'b0;
        checkOutput("blank off", 1'b0, {G0, G0, G0, G7});

        // Load request during a conversion is dropped
        @(negedge SSDClk);
        value = 13'd1234; signed_mode = 1'b0; blank_lz = 1'b0; value_valid = 1'b1;
        @(negedge SSDClk);
        value_valid = 1'b0;
        repeat (2) @(negedge SSDClk);
        value = 13'd5555; value_valid = 1'b1;
        @(negedge SSDClk);
        value_valid = 1'b0; value = '0;
        n = 0;
        while (busy && n < BOUND) begin
            @(negedge SSDClk);
            n++;
        end
        compareValue("busy ends after dropped request", 32'(busy), 32'h0);
        repeat (4) @(negedge SSDClk);
        compareValue("no second conversion", 32'(busy), 32'h0);
        checkOutput("dropped request", 1'b0, {G1, G2, G3, G4});

        // Reset during a conversion abandons it
        @(negedge SSDClk);
        value = 13'd8191; value_valid = 1'b1;
        @(negedge SSDClk);
        value_valid = 1'b0;
        repeat (3) @(negedge SSDClk);
        rst = 1'b0;
        @(negedge SSDClk);
        rst = 1'b1;
        compareValue("busy after mid reset", 32'(busy), 32'h0);
        repeat (20) @(negedge SSDClk);
        compareValue("no commit after mid reset", 32'(busy), 32'h0);
        checkOutput("mid reset", 1'b0, {G0, G0, G0, G0});

        // Randomised loads against the decimal model
        for (int k = 0; k < 40; k++) begin
            rv  = IW'($urandom_range(0, (1 << IW) - 1));
            rsm = 1'($urandom_range(0, 1));
            rbl = 1'($urandom_range(0, 1));
            modelDisplay(rv, rsm, rbl, movf, msegs);
            applyStimulus(rv, rsm, rbl, bc);
            compareValue($sformatf("rand%0d busy cycles", k), 32'(bc), 32'd14);
            checkOutput($sformatf("rand%0d v=%0d s=%0d b=%0d", k, rv, rsm, rbl), movf, msegs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
